// File: rtl/pc_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_defs_pkg
//  Description : Shared next-PC mode encodings. Both the PC sequencer and the
//                control-unit decoder use these so the two sides cannot drift.
//                Codes 5..7 are reserved and behave as HOLD.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_defs_pkg;

    localparam int PC_SRC_W = 3;

    typedef enum logic [PC_SRC_W-1:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_CALL   = 3'd3,
        PC_RET    = 3'd4
    } pc_src_e;

    // True for the five defined modes; anything else is a HOLD.
    function automatic logic pc_src_is_active(input logic [PC_SRC_W-1:0] src);
        return (src <= PC_RET);
    endfunction

endpackage : pc_defs_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack (LIFO).
//                A push while full overwrites the oldest entry and keeps the
//                count saturated. A pop while empty leaves the state untouched.
//                overflow/underflow are same-cycle indications of misuse.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                push, push_data     write an entry
//                pop                 discard the top entry
//                top_data            current top entry (valid when !empty)
//                full, empty         derived from the registered count
//                overflow, underflow push-while-full / pop-while-empty
//  Revision    : 1.0  initial release
// ============================================================================
module ras_stack #(
    parameter int WIDTH     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    // wr_ptr is the next free slot; since depth is a power of two the pointer
    // wraps naturally. When full it also addresses the oldest entry, which is
    // exactly the slot an overflowing push must replace.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign top_data  = mem[wr_ptr - PTR_W'(1)];
    assign overflow  = push & full;
    assign underflow = pop & empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - (PTR_W+1)'(1);
        end
    end

    // Storage carries no reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer: next-PC mux, PC register and a
//                sticky return-stack misuse flag. Return addresses live in
//                ras_stack. One-cycle latency, all outputs registered-state.
//  Ports       : Clock, Reset        clock, synchronous active-high reset
//                PCWrite             update enable (0 = stall everything)
//                PCSrc               next-PC mode (pc_defs_pkg encodings)
//                PCTarget            absolute target or signed branch offset
//                PCOut               current PC
//                RASFull, RASEmpty   stack status
//                RASError            sticky overflow/underflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_defs_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int STEP         = 1,
    parameter int RESET_VECTOR = 0,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                PCWrite,
    input  logic [PC_SRC_W-1:0] PCSrc,
    input  logic [WIDTH-1:0]    PCTarget,
    output logic [WIDTH-1:0]    PCOut,
    output logic                RASFull,
    output logic                RASEmpty,
    output logic                RASError
);

    localparam logic [WIDTH-1:0] RV   = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] INCR = WIDTH'(STEP);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] seq_addr;
    logic [WIDTH-1:0] top_data;
    logic             push;
    logic             pop;
    logic             stk_full;
    logic             stk_empty;
    logic             overflow;
    logic             underflow;
    logic             error;

    assign seq_addr = pc + INCR;

    // Branch offsets are two's complement, so a plain modulo-2^WIDTH add
    // gives the signed result without explicit sign extension.
    always_comb begin
        next_pc = pc;
        push    = 1'b0;
        pop     = 1'b0;
        case (PCSrc)
            PC_SEQ:    next_pc = seq_addr;
            PC_BRANCH: next_pc = pc + PCTarget;
            PC_JUMP:   next_pc = PCTarget;
            PC_CALL: begin
                next_pc = PCTarget;
                push    = PCWrite;
            end
            PC_RET: begin
                next_pc = stk_empty ? RV : top_data;
                pop     = PCWrite;
            end
            default:   next_pc = pc;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc    <= RV;
            error <= 1'b0;
        end else if (PCWrite) begin
            pc <= next_pc;
            if (overflow || underflow) begin
                error <= 1'b1;
            end
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (seq_addr),
        .top_data  (top_data),
        .full      (stk_full),
        .empty     (stk_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign PCOut    = pc;
    assign RASFull  = stk_full;
    assign RASEmpty = stk_empty;
    assign RASError = error;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer (WIDTH=8, STEP=1,
//                RAS_DEPTH=4, RESET_VECTOR=0). Directed scenarios followed by
//                random traffic, compared against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int W     = 8;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
    localparam int RV    = 0;

    localparam logic [2:0] SEQ = 3'd0, BRA = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         PCWrite;
    logic [2:0]   PCSrc;
    logic [W-1:0] PCTarget;
    logic [W-1:0] PCOut;
    logic         RASFull;
    logic         RASEmpty;
    logic         RASError;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pc  = RV;
    int m_q[$];
    bit m_err = 1'b0;

    pc_sequencer #(
        .WIDTH        (W),
        .STEP         (STEP),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .PCTarget (PCTarget),
        .PCOut    (PCOut),
        .RASFull  (RASFull),
        .RASEmpty (RASEmpty),
        .RASError (RASError)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural model: the stack is a queue whose back is the top.
    task automatic model_step(input logic rst, input logic we, input logic [2:0] src,
                              input logic [W-1:0] tgt);
        int off;
        if (rst) begin
            m_pc  = RV;
            m_q.delete();
            m_err = 1'b0;
        end else if (we) begin
            case (src)
                3'd0: m_pc = (m_pc + STEP) % 256;
                3'd1: begin
                    off  = (int'(tgt) < 128) ? int'(tgt) : int'(tgt) - 256;
                    m_pc = (m_pc + off + 256) % 256;
                end
                3'd2: m_pc = int'(tgt);
                3'd3: begin
                    if (m_q.size() == DEPTH) begin
                        void'(m_q.pop_front());
                        m_err = 1'b1;
                    end
                    m_q.push_back((m_pc + STEP) % 256);
                    m_pc = int'(tgt);
                end
                3'd4: begin
                    if (m_q.size() == 0) begin
                        m_pc  = RV;
                        m_err = 1'b1;
                    end else begin
                        m_pc = m_q.pop_back();
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic we,
                       input logic [2:0] src, input logic [W-1:0] tgt);
        Reset    = rst;
        PCWrite  = we;
        PCSrc    = src;
        PCTarget = tgt;
        @(posedge Clock);
        #1;
        model_step(rst, we, src, tgt);
        chk({tag, ".pc"},    32'(PCOut),    32'(m_pc));
        chk({tag, ".empty"}, 32'(RASEmpty), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(RASFull),  32'(m_q.size() == DEPTH));
        chk({tag, ".err"},   32'(RASError), 32'(m_err));
    endtask

    initial begin
        Reset = 1'b1; PCWrite = 1'b0; PCSrc = SEQ; PCTarget = '0;
        #2;

        // Reset state
        cyc("rst", 1'b1, 1'b0, SEQ, 8'h00);
        chk("rst_pc_lit", 32'(PCOut), 32'h00);
        chk("rst_empty_lit", 32'(RASEmpty), 32'h1);

        // Sequential and wrap-around
        repeat (3) cyc("seq", 1'b0, 1'b1, SEQ, 8'h00);
        chk("seq3_lit", 32'(PCOut), 32'h03);
        cyc("jmp_ff", 1'b0, 1'b1, JMP, 8'hFF);
        cyc("wrap", 1'b0, 1'b1, SEQ, 8'h00);
        chk("wrap_lit", 32'(PCOut), 32'h00);
        chk("wrap_err_lit", 32'(RASError), 32'h0);

        // Branches both directions, jump
        cyc("jmp10", 1'b0, 1'b1, JMP, 8'h10);
        cyc("bra_neg", 1'b0, 1'b1, BRA, 8'hFC);
        chk("bra_neg_lit", 32'(PCOut), 32'h0C);
        cyc("bra_pos", 1'b0, 1'b1, BRA, 8'h05);
        chk("bra_pos_lit", 32'(PCOut), 32'h11);
        cyc("jmpA0", 1'b0, 1'b1, JMP, 8'hA0);
        chk("jmpA0_lit", 32'(PCOut), 32'hA0);

        // Call / return
        cyc("jmp05", 1'b0, 1'b1, JMP, 8'h05);
        cyc("call40", 1'b0, 1'b1, CALL, 8'h40);
        chk("call40_lit", 32'(PCOut), 32'h40);
        cyc("ret", 1'b0, 1'b1, RET, 8'h00);
        chk("ret_lit", 32'(PCOut), 32'h06);

        // Stall holds everything
        repeat (3) cyc("stall", 1'b0, 1'b0, CALL, 8'h80);
        chk("stall_lit", 32'(PCOut), 32'h06);

        // Overflow / underflow
        cyc("jmp00", 1'b0, 1'b1, JMP, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc("ovf_call", 1'b0, 1'b1, CALL, 8'((i + 1) * 16));
            if (i == 3) chk("full4_lit", 32'(RASFull), 32'h1);
        end
        chk("ovf_err_lit", 32'(RASError), 32'h1);
        for (int i = 0; i < 5; i++) cyc("unf_ret", 1'b0, 1'b1, RET, 8'h00);
        chk("unf_pc_lit", 32'(PCOut), 32'h00);

        // Reset mid-sequence discards stack, has priority
        cyc("rst2", 1'b1, 1'b0, SEQ, 8'h00);
        cyc("c1", 1'b0, 1'b1, CALL, 8'h30);
        cyc("c2", 1'b0, 1'b1, CALL, 8'h50);
        cyc("rst_call", 1'b1, 1'b1, CALL, 8'h77);
        chk("rst_call_pc_lit", 32'(PCOut), 32'h00);
        chk("rst_call_err_lit", 32'(RASError), 32'h0);
        cyc("post_rst_ret", 1'b0, 1'b1, RET, 8'h00);
        chk("post_rst_err_lit", 32'(RASError), 32'h1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cyc("rand",
                ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 8),
                3'($urandom_range(0, 7)),
                8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, program-counter width in bits.
REQ-002 Parameter STEP, default 1, sequential increment added to the PC.
REQ-003 Parameter RESET_VECTOR, default 0, PC value after reset and after return-stack underflow.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (>=2, power of two).
REQ-005 Clock  input  1  single clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 PCWrite  input  1  update enable; 0 = stall, all state held.
REQ-008 PCSrc  input  3  next-PC mode select (encodings in REQ-011).
REQ-009 PCTarget  input  WIDTH  absolute target (JUMP/CALL) or two's-complement offset (BRANCH).
REQ-010 PCOut  output  WIDTH  registered current PC; RASFull/RASEmpty/RASError  output  1 each  stack full, stack empty, sticky misuse flag.

Function
REQ-011 PCSrc encodings: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; 5-7 reserved = HOLD (no state change).
REQ-012 SEQ: PCOut <= PCOut + STEP.
REQ-013 BRANCH: PCOut <= PCOut + PCTarget, PCTarget interpreted as signed WIDTH-bit offset.
REQ-014 JUMP: PCOut <= PCTarget.
REQ-015 CALL: push PCOut + STEP onto stack, PCOut <= PCTarget, same edge.
REQ-016 RET: pop top of stack into PCOut, same edge.
REQ-017 All PC arithmetic modulo 2^WIDTH; wrap-around silent, not an error.
REQ-018 Latency: one cycle; inputs sampled at rising edge, PCOut valid after that edge; no combinational input-to-output path.
REQ-019 PCWrite=0: PCOut, stack contents, stack count and RASError unchanged regardless of PCSrc.
REQ-020 Stack is LIFO; RASEmpty = (count==0), RASFull = (count==RAS_DEPTH), both registered-state derived.
REQ-021 CALL when full: oldest entry overwritten (circular), count stays RAS_DEPTH, RASError set.
REQ-022 RET when empty: PCOut <= RESET_VECTOR, count stays 0, RASError set.
REQ-023 RASError sticky; cleared only by Reset.

Reset
REQ-024 Reset has priority over PCWrite and PCSrc.
REQ-025 On Reset: PCOut=RESET_VECTOR, count=0, RASEmpty=1, RASFull=0, RASError=0; stack contents don't-care.
REQ-026 Reset asserted mid-sequence discards pending stack state; first post-reset RET is an underflow.

Structure
REQ-027 PCSrc encoding constants shared in package pc_defs_pkg, used by pc_sequencer and control-unit decoder.
REQ-028 Return stack implemented as one sub-module ras_stack (circular LIFO, push/pop/full/empty/overflow/underflow), parametrised by WIDTH and RAS_DEPTH.
REQ-029 pc_sequencer top contains only next-PC mux, PC register and error flag.

Verification (WIDTH=8, STEP=1, RAS_DEPTH=4, RESET_VECTOR=0)
REQ-030 Reset, then SEQ x3 -> PCOut 0,1,2,3; JUMP 0xFF then SEQ -> 0xFF then 0x00, RASError=0.
REQ-031 PC=0x10, BRANCH PCTarget=0xFC -> 0x0C; BRANCH 0x05 -> 0x11; JUMP 0xA0 -> 0xA0.
REQ-032 PC=0x05, CALL 0x40 -> PC=0x40, RASEmpty=0; RET -> PC=0x06, RASEmpty=1.
REQ-033 PCWrite=0 with CALL 0x80 for 3 cycles -> PCOut, RASEmpty, RASError unchanged.
REQ-034 Five CALLs from PCs 0x00,0x10,0x20,0x30,0x40 to next 0x10..0x50 -> RASFull after 4th, RASError after 5th; 4 RETs -> 0x41,0x31,0x21,0x11; 5th RET -> 0x00.
REQ-035 Two CALLs then Reset with PCSrc=CALL, PCWrite=1 -> PC=0x00, RASEmpty=1, RASError=0; following RET -> PC=0x00, RASError=1.
